// File: rtl/note_channel.sv
// Single pulse-wave tone voice driven by the top sequencer state bus.
// Optional duty-cycle select port enabled by NOTE_CHANNEL_DUTY_EN.
module note_channel #(
  parameter int PERIOD_W = 16,
  parameter int VOL_W    = 4,
  parameter int GATE_W   = 24,
  parameter int ENV_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          state,
  input  logic [PERIOD_W-1:0] note_period,
  input  logic [VOL_W-1:0]    note_volume,
  input  logic [GATE_W-1:0]   note_gate,
  input  logic [ENV_W-1:0]    env_decay,
`ifdef NOTE_CHANNEL_DUTY_EN
  input  logic [1:0]          note_duty,
`endif
  output logic [VOL_W-1:0]    sample,
  output logic                active,
  output logic                done
);

  localparam logic [1:0] ST_LOAD  = 2'b01;
  localparam logic [1:0] ST_START = 2'b10;
  localparam logic [1:0] ST_PLAY  = 2'b11;

  typedef enum logic {SILENT, PLAYING} ch_state_t;

  ch_state_t r_fsm;
  ch_state_t w_fsm_nxt;

  logic [PERIOD_W-1:0] r_period;
  logic [VOL_W-1:0]    r_volume;
  logic [GATE_W-1:0]   r_gate;
  logic [ENV_W-1:0]    r_decay;
  logic [PERIOD_W-1:0] r_phase;
  logic [GATE_W-1:0]   r_gate_cnt;
  logic [ENV_W-1:0]    r_env_cnt;
  logic [VOL_W-1:0]    r_cur_vol;
  logic [VOL_W-1:0]    r_sample;
  logic                r_done;

  logic                w_clear;
  logic                w_rest;
  logic                w_gate_exp;
  logic                w_env_step;
  logic                w_env_exp;
  logic                w_expire;
  logic                w_level;
  logic [VOL_W-1:0]    w_vol_dec;
  logic [PERIOD_W-1:0] w_thresh;

`ifdef NOTE_CHANNEL_DUTY_EN
  logic [1:0] r_duty;

  always_comb begin
    w_thresh = r_period >> 1;
    unique case (r_duty)
      2'b00: w_thresh = r_period >> 3;
      2'b01: w_thresh = r_period >> 2;
      2'b10: w_thresh = r_period >> 1;
      2'b11: w_thresh = r_period - (r_period >> 2);
    endcase
  end
`else
  assign w_thresh = r_period >> 1;
`endif

  assign w_clear    = reset || (state == 2'b00);
  assign w_rest     = (r_period < 2) || (r_volume == '0) ||
                      (r_gate == '0);
  assign w_level    = (r_phase < w_thresh);
  assign w_gate_exp = (r_gate_cnt == GATE_W'(1));
  assign w_env_step = (r_decay != '0) && (r_env_cnt == ENV_W'(1));
  assign w_vol_dec  = (r_cur_vol == '0) ? '0 : r_cur_vol - VOL_W'(1);
  assign w_env_exp  = w_env_step && (w_vol_dec == '0);
  assign w_expire   = w_gate_exp || w_env_exp;

  always_comb begin
    w_fsm_nxt = r_fsm;
    if (state == ST_START)
      w_fsm_nxt = w_rest ? SILENT : PLAYING;
    else if (state == ST_PLAY && r_fsm == PLAYING && w_expire)
      w_fsm_nxt = SILENT;
  end

  always_ff @(posedge clk) begin
    if (w_clear) r_fsm <= SILENT;
    else         r_fsm <= w_fsm_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_period   <= '0;
      r_volume   <= '0;
      r_gate     <= '0;
      r_decay    <= '0;
      r_phase    <= '0;
      r_gate_cnt <= '0;
      r_env_cnt  <= '0;
      r_cur_vol  <= '0;
      r_sample   <= '0;
      r_done     <= 1'b0;
`ifdef NOTE_CHANNEL_DUTY_EN
      r_duty     <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (state)
        ST_LOAD: begin
          r_period <= note_period;
          r_volume <= note_volume;
          r_gate   <= note_gate;
          r_decay  <= env_decay;
`ifdef NOTE_CHANNEL_DUTY_EN
          r_duty   <= note_duty;
`endif
        end
        ST_START: begin
          r_phase    <= '0;
          r_gate_cnt <= r_gate;
          r_env_cnt  <= r_decay;
          r_cur_vol  <= r_volume;
          r_sample   <= '0;
        end
        ST_PLAY: begin
          if (r_fsm == PLAYING) begin
            r_phase <= (r_phase == r_period - PERIOD_W'(1)) ?
                       '0 : r_phase + PERIOD_W'(1);
            r_gate_cnt <= r_gate_cnt - GATE_W'(1);
            if (r_decay != '0) begin
              if (w_env_step) begin
                r_env_cnt <= r_decay;
                r_cur_vol <= w_vol_dec;
              end else begin
                r_env_cnt <= r_env_cnt - ENV_W'(1);
              end
            end
            // the expiring edge silences output and raises done together
            if (w_expire) begin
              r_sample <= '0;
              r_done   <= 1'b1;
            end else begin
              r_sample <= w_level ? r_cur_vol : '0;
            end
          end else begin
            r_sample <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign sample = r_sample;
  assign active = (r_fsm == PLAYING);
  assign done   = r_done;

endmodule

// File: tb/tb_note_channel.sv
// Directed self-checking bench for note_channel.
// Duty-cycle scenario compiled only with NOTE_CHANNEL_DUTY_EN.
module tb_note_channel;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  state;
  logic [15:0] note_period;
  logic [3:0]  note_volume;
  logic [23:0] note_gate;
  logic [15:0] env_decay;
  logic [1:0]  note_duty;
  logic [3:0]  sample;
  logic        active;
  logic        done;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  note_channel dut (
    .clk(clk),
    .reset(reset),
    .state(state),
    .note_period(note_period),
    .note_volume(note_volume),
    .note_gate(note_gate),
    .env_decay(env_decay),
`ifdef NOTE_CHANNEL_DUTY_EN
    .note_duty(note_duty),
`endif
    .sample(sample),
    .active(active),
    .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_note(input logic [15:0] p, input logic [3:0] v,
                           input logic [23:0] g, input logic [15:0] e,
                           input logic [1:0] d);
    note_period = p;
    note_volume = v;
    note_gate   = g;
    env_decay   = e;
    note_duty   = d;
    state       = 2'b01;
    tick();
  endtask

  task automatic test_reset();
    load_note(16'($urandom_range(2, 20)), 4'($urandom_range(1, 15)),
              24'($urandom_range(30, 60)), 16'($urandom_range(0, 5)),
              2'($urandom_range(0, 3)));
    state = 2'b10;
    tick();
    state = 2'b11;
    for (int i = 0; i < 7; i++) tick();
    state = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++;
      if (sample !== 4'd0 || active !== 1'b0 || done !== 1'b0) begin
        errs++;
        $display("FAIL reset[%0d]: s=%0d a=%b d=%b want 0 0 0",
                 i, sample, active, done);
      end
    end
    // shadows cleared: a START straight after reset must rest
    state = 2'b10;
    tick();
    vecs++;
    if (active !== 1'b0) begin
      errs++;
      $display("FAIL reset_shadow: active=%b want 0", active);
    end
    // reset input alone clears an active note
    load_note(16'd8, 4'd7, 24'd50, 16'd0, 2'b10);
    state = 2'b10;
    tick();
    state = 2'b11;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vecs++;
    if (sample !== 4'd0 || active !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL reset_pin: s=%0d a=%b d=%b want 0 0 0",
               sample, active, done);
    end
  endtask

  task automatic test_basic_tone();
    logic [3:0] es;
    load_note(16'd8, 4'd9, 24'd40, 16'd0, 2'b10);
    state = 2'b10;
    tick();
    vecs++;
    if (active !== 1'b1 || sample !== 4'd0 || done !== 1'b0) begin
      errs++;
      $display("FAIL tone_start: a=%b s=%0d d=%b want 1 0 0",
               active, sample, done);
    end
    state = 2'b11;
    for (int k = 1; k <= 45; k++) begin
      tick();
      es = (k < 40 && ((k - 1) % 8) < 4) ? 4'd9 : 4'd0;
      vecs++;
      if (sample !== es || active !== (k < 40) ||
          done !== (k == 40)) begin
        errs++;
        $display("FAIL tone[%0d]: s=%0d a=%b d=%b want %0d %b %b",
                 k, sample, active, done, es, k < 40, k == 40);
      end
    end
  endtask

  task automatic test_envelope();
    logic [3:0] v;
    logic [3:0] es;
    load_note(16'd4, 4'd3, 24'd1000, 16'd10, 2'b10);
    state = 2'b10;
    tick();
    state = 2'b11;
    for (int k = 1; k <= 34; k++) begin
      tick();
      v  = (k <= 10) ? 4'd3 : (k <= 20) ? 4'd2 : 4'd1;
      es = (k < 30 && ((k - 1) % 4) < 2) ? v : 4'd0;
      vecs++;
      if (sample !== es || active !== (k < 30) ||
          done !== (k == 30)) begin
        errs++;
        $display("FAIL env[%0d]: s=%0d a=%b d=%b want %0d %b %b",
                 k, sample, active, done, es, k < 30, k == 30);
      end
    end
  endtask

  task automatic test_rest();
    logic [15:0] p [3] = '{16'd1, 16'd8, 16'd8};
    logic [3:0]  v [3] = '{4'd5, 4'd0, 4'd5};
    logic [23:0] g [3] = '{24'd20, 24'd20, 24'd0};
    int bad;
    for (int c = 0; c < 3; c++) begin
      load_note(p[c], v[c], g[c], 16'd0, 2'b10);
      state = 2'b10;
      tick();
      state = 2'b11;
      bad = 0;
      for (int k = 0; k < 25; k++) begin
        tick();
        if (sample !== 4'd0 || active !== 1'b0 || done !== 1'b0)
          bad++;
      end
      vecs++;
      if (bad != 0) begin
        errs++;
        $display("FAIL rest[%0d]: %0d non-silent cycles, want 0",
                 c, bad);
      end
    end
  endtask

  task automatic test_retrigger();
    logic [3:0] es;
    int dn;
    load_note(16'd8, 4'd9, 24'd100, 16'd0, 2'b10);
    state = 2'b10;
    tick();
    state = 2'b11;
    dn = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done !== 1'b0) dn++;
    end
    load_note(16'd8, 4'd2, 24'd100, 16'd0, 2'b10);
    vecs++;
    if (active !== 1'b1 || sample !== 4'd9 || done !== 1'b0) begin
      errs++;
      $display("FAIL retrig_load: a=%b s=%0d d=%b want 1 9 0",
               active, sample, done);
    end
    state = 2'b10;
    tick();
    vecs++;
    if (active !== 1'b1 || done !== 1'b0) begin
      errs++;
      $display("FAIL retrig_start: a=%b d=%b want 1 0", active, done);
    end
    state = 2'b11;
    for (int k = 1; k <= 16; k++) begin
      tick();
      es = (((k - 1) % 8) < 4) ? 4'd2 : 4'd0;
      if (done !== 1'b0) dn++;
      vecs++;
      if (sample !== es || active !== 1'b1) begin
        errs++;
        $display("FAIL retrig[%0d]: s=%0d a=%b want %0d 1",
                 k, sample, active, es);
      end
    end
    vecs++;
    if (dn != 0) begin
      errs++;
      $display("FAIL retrig_done: %0d done pulses, want 0", dn);
    end
  endtask

`ifdef NOTE_CHANNEL_DUTY_EN
  task automatic test_duty();
    logic [1:0] d [3] = '{2'b00, 2'b01, 2'b11};
    int         w [3] = '{2, 4, 12};
    int hi;
    for (int c = 0; c < 3; c++) begin
      load_note(16'd16, 4'd5, 24'd100, 16'd0, d[c]);
      state = 2'b10;
      tick();
      state = 2'b11;
      hi = 0;
      for (int k = 0; k < 16; k++) begin
        tick();
        if (sample == 4'd5) hi++;
      end
      vecs++;
      if (hi != w[c]) begin
        errs++;
        $display("FAIL duty[%0d]: high=%0d want %0d", c, hi, w[c]);
      end
    end
  endtask
`endif

  initial begin
    reset       = 1'b1;
    state       = 2'b00;
    note_period = '0;
    note_volume = '0;
    note_gate   = '0;
    env_decay   = '0;
    note_duty   = 2'b10;
    tick();
    tick();
    reset = 1'b0;
    test_reset();
    test_basic_tone();
    test_envelope();
    test_rest();
    test_retrigger();
`ifdef NOTE_CHANNEL_DUTY_EN
    test_duty();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/note_channel.md
Name: note_channel

Overview:
- Single tone-generator voice. It is the responder to the top-level sequencing FSM: it consumes that FSM's 2-bit state bus (RESET/LOAD/START/PLAY).
- Latches note parameters during LOAD, restarts phase, gate and envelope on START, and generates a pulse waveform with gate-length and volume-decay envelope during PLAY.
- Several instances feed the output mixer, one per channel.

Parameters:
- PERIOD_W, 16, width of note period (clk cycles per waveform period).
- VOL_W, 4, width of volume/sample magnitude.
- GATE_W, 24, width of gate (sounding duration) counter; matches the top FSM's length width.
- ENV_W, 16, width of envelope step interval.

Ports:
- clk  in  1  system clock, 2^22 Hz.
- reset  in  1  synchronous, active-high reset.
- state  in  2  top FSM state: 00=RESET, 01=LOAD, 10=START, 11=PLAY.
- note_period  in  PERIOD_W  full waveform period in cycles; values 0 or 1 = rest.
- note_volume  in  VOL_W  initial volume.
- note_gate  in  GATE_W  cycles the note sounds after START; 0 = rest.
- env_decay  in  ENV_W  cycles per volume decrement; 0 = no decay.
- sample  out  VOL_W  registered output: current volume while waveform high, else 0.
- active  out  1  high while channel FSM is in PLAYING.
- done  out  1  one-cycle pulse on the PLAYING->SILENT transition.

Behaviour:
- Reset: reset=1 or state==00 (synchronous) clears everything.
  - sample=0, active=0, done=0.
  - All shadow registers and counters = 0.
  - Channel FSM = SILENT.
- Channel FSM has two states: SILENT, PLAYING.
- LOAD (state==01):
  - Latch note_period, note_volume, note_gate, env_decay into shadow registers.
  - Channel FSM, counters and outputs are unaffected; a note still PLAYING continues to sound through LOAD.
- START (state==10), applied using the shadow values:
  - phase<=0, gate_cnt<=gate, env_cnt<=decay, cur_vol<=volume.
  - FSM<=PLAYING, unless period<2, volume==0 or gate==0; in those cases FSM<=SILENT.
  - done is not pulsed in START.
- PLAY (state==11) with FSM==PLAYING, each cycle:
  - phase<=(phase==period-1) ? 0 : phase+1.
  - level = (phase < threshold), threshold = period>>1.
  - sample<=level ? cur_vol : 0, registered, so one cycle latency from phase.
  - gate_cnt decrements. When gate_cnt==1: FSM<=SILENT, done<=1 for one cycle, sample<=0 on the same edge.
  - If decay!=0: env_cnt decrements. When env_cnt==1: env_cnt<=decay and cur_vol<=cur_vol-1, saturating at 0. If the new cur_vol would be 0: FSM<=SILENT, done pulse.
  - Gate expiry and envelope expiry on the same cycle: a single done pulse, FSM<=SILENT.
- PLAY with FSM==SILENT: sample=0, active=0, counters hold.
- active is the registered FSM==PLAYING.
- START arriving while PLAYING (top tempo shorter than gate):
  - Note is retriggered immediately from the shadow values.
  - No done pulse.
- Widths:
  - All counters are unsigned, no wrap.
  - phase has PERIOD_W bits; gate_cnt has GATE_W bits; env_cnt has ENV_W bits.
- Timing: first non-zero sample appears on the first PLAY edge after START (phase=0 -> level=1).

Optional Feature:
- Macro NOTE_CHANNEL_DUTY_EN.
- Defined:
  - Adds input port note_duty[1:0], latched at LOAD.
  - threshold = period>>3 (00, 12.5%), period>>2 (01, 25%), period>>1 (10, 50%), period-(period>>2) (11, 75%).
  - Rest rule unchanged.
- Undefined:
  - Port absent; threshold fixed at period>>1.

Test Plan:
1. Reset: drive state=00 for 3 cycles after random activity -> sample=0, active=0, done=0 on the following edge, and hold.
2. Basic tone: LOAD period=8, vol=9, gate=40, decay=0; then START, then PLAY -> sample toggles 9,9,9,9,0,0,0,0 repeating; active=1 for 40 PLAY cycles; done pulses once on the 40th; sample=0 afterwards.
3. Envelope: LOAD period=4, vol=3, gate=1000, decay=10 -> cur_vol steps 3->2->1 at PLAY cycles 10 and 20; at cycle 30 FSM goes SILENT with a single done pulse, before the gate expires.
4. Rest/boundaries: (period=1, vol=5, gate=20), (period=8, vol=0, gate=20) and (period=8, vol=5, gate=0) -> active stays 0, sample=0, no done pulse.
5. Retrigger and LOAD-transparency: gate=100, top sequence LOAD/START/PLAY×20/LOAD/START, with new vol=2 at the second LOAD -> tone continues through the second LOAD, restarts at phase 0 with amplitude 2 after the second START, no done pulse.
6. (NOTE_CHANNEL_DUTY_EN) period=16, duty=00/01/11 -> high run of 2/4/12 cycles per 16-cycle period.
